// File: rtl/unidade_controle_exp7_pkg.sv
// Shared state codes, output bundle and default timer constants for the exp7 control unit.
// The top level and the benches decode db_estado with estado_t.
package unidade_controle_exp7_pkg;

   localparam int unsigned MOSTRA_CICLOS_PADRAO  = 1000;
   localparam int unsigned TIMEOUT_CICLOS_PADRAO = 3000;

   typedef enum logic [3:0] {
      INICIAL          = 4'h0,
      PREPARACAO       = 4'h1,
      MOSTRA           = 4'h2,
      ESPERA_JOGADA    = 4'h3,
      REGISTRA         = 4'h4,
      COMPARA          = 4'h5,
      PROXIMA_JOGADA   = 4'h6,
      AVANCA_ESCRITA   = 4'h7,
      ESPERA_ESCRITA   = 4'h8,
      REGISTRA_ESCRITA = 4'h9,
      ESCREVE          = 4'hA,
      PROXIMA_RODADA   = 4'hB,
      FIM_ACERTOU      = 4'hC,
      FIM_ERROU        = 4'hD,
      FIM_TIMEOUT      = 4'hE
   } estado_t;

   typedef struct packed {
      logic zeraE;
      logic contaE;
      logic zeraR;
      logic contaR;
      logic registraR;
      logic escreveM;
      logic leds_mostra;
      logic pronto;
      logic ganhou;
      logic perdeu;
      logic db_timeout;
   } saidas_t;

   // Moore decode: the outputs depend on the state alone.
   function automatic saidas_t decodifica(input estado_t e);
      saidas_t s;
      s = '0;
      case (e)
         PREPARACAO:       begin s.zeraE = 1'b1; s.zeraR = 1'b1; end
         MOSTRA:           s.leds_mostra = 1'b1;
         REGISTRA:         s.registraR = 1'b1;
         PROXIMA_JOGADA:   s.contaE = 1'b1;
         AVANCA_ESCRITA:   s.contaE = 1'b1;
         REGISTRA_ESCRITA: s.registraR = 1'b1;
         ESCREVE:          s.escreveM = 1'b1;
         PROXIMA_RODADA:   begin s.contaR = 1'b1; s.zeraE = 1'b1; end
         FIM_ACERTOU:      begin s.pronto = 1'b1; s.ganhou = 1'b1; end
         FIM_ERROU:        begin s.pronto = 1'b1; s.perdeu = 1'b1; end
         FIM_TIMEOUT:      begin s.pronto = 1'b1; s.perdeu = 1'b1; s.db_timeout = 1'b1; end
         default:          s = '0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/unidade_controle_exp7_contador_m.sv
// Modulo-M timer with synchronous clear (zera) taking priority over count (conta).
// fim flags the terminal value M-1.
module contador_m #(
   parameter int unsigned M = 3000,
   parameter int unsigned N = 12
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         zera,
   input  logic         conta,
   output logic [N-1:0] q,
   output logic         fim
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (zera) begin
         q <= '0;
      end else if (conta) begin
         if (q == N'(M - 1)) q <= '0;
         else                q <= q + 1'b1;
      end
   end

   assign fim = (q == N'(M - 1));

endmodule

// File: rtl/unidade_controle_exp7.sv
// Control unit for the exp7 memory game: Moore FSM sequencing the datapath,
// owning the LED-display timer and the play-timeout timer.
module unidade_controle_exp7
   import unidade_controle_exp7_pkg::*;
#(
   parameter int unsigned MOSTRA_CICLOS  = MOSTRA_CICLOS_PADRAO,
   parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada,
   input  logic       igual,
   input  logic       enderecoIgualRodada,
   input  logic       fimR,
   output logic       zeraE,
   output logic       contaE,
   output logic       zeraR,
   output logic       contaR,
   output logic       registraR,
   output logic       escreveM,
   output logic       leds_mostra,
   output logic       pronto,
   output logic       ganhou,
   output logic       perdeu,
   output logic       db_timeout,
   output logic [3:0] db_estado
);

   localparam int unsigned M = (MOSTRA_CICLOS > TIMEOUT_CICLOS) ? MOSTRA_CICLOS : TIMEOUT_CICLOS;
   localparam int unsigned N = (M > 1) ? $clog2(M) : 1;

   estado_t      estado, proximo;
   saidas_t      saidas;
   logic [N-1:0] timer;
   logic         timer_fim, fim_mostra, fim_espera, zera_timer, conta_timer;

   // One shared timer: cleared on entry to a timed state, counting while inside it.
   assign zera_timer  = (proximo != estado) &&
                        (proximo inside {MOSTRA, ESPERA_JOGADA, ESPERA_ESCRITA});
   assign conta_timer = estado inside {MOSTRA, ESPERA_JOGADA, ESPERA_ESCRITA};

   contador_m #(.M(M), .N(N)) timer_jogo (
      .clock (clock),
      .reset (reset),
      .zera  (zera_timer),
      .conta (conta_timer),
      .q     (timer),
      .fim   (timer_fim)
   );

   assign fim_mostra = (timer == N'(MOSTRA_CICLOS - 1));
   assign fim_espera = (TIMEOUT_CICLOS >= MOSTRA_CICLOS) ? timer_fim
                                                         : (timer == N'(TIMEOUT_CICLOS - 1));

   always_comb begin
      proximo = estado;
      case (estado)
         INICIAL:          if (iniciar) proximo = PREPARACAO;
         PREPARACAO:       proximo = MOSTRA;
         MOSTRA:           if (fim_mostra) proximo = ESPERA_JOGADA;
         // jogada outranks a timeout landing on the same clock
         ESPERA_JOGADA:    if (jogada) proximo = REGISTRA;
                           else if (fim_espera) proximo = FIM_TIMEOUT;
         REGISTRA:         proximo = COMPARA;
         COMPARA:          if (!igual)                   proximo = FIM_ERROU;
                           else if (!enderecoIgualRodada) proximo = PROXIMA_JOGADA;
                           else if (fimR)                proximo = FIM_ACERTOU;
                           else                          proximo = AVANCA_ESCRITA;
         PROXIMA_JOGADA:   proximo = ESPERA_JOGADA;
         AVANCA_ESCRITA:   proximo = ESPERA_ESCRITA;
         ESPERA_ESCRITA:   if (jogada) proximo = REGISTRA_ESCRITA;
                           else if (fim_espera) proximo = FIM_TIMEOUT;
         REGISTRA_ESCRITA: proximo = ESCREVE;
         ESCREVE:          proximo = PROXIMA_RODADA;
         PROXIMA_RODADA:   proximo = ESPERA_JOGADA;
         FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
                           if (iniciar) proximo = PREPARACAO;
         default:          proximo = INICIAL;
      endcase
   end

   // Outputs registered from the next state so they line up with the state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado <= INICIAL;
         saidas <= '0;
      end else begin
         estado <= proximo;
         saidas <= decodifica(proximo);
      end
   end

   assign zeraE       = saidas.zeraE;
   assign contaE      = saidas.contaE;
   assign zeraR       = saidas.zeraR;
   assign contaR      = saidas.contaR;
   assign registraR   = saidas.registraR;
   assign escreveM    = saidas.escreveM;
   assign leds_mostra = saidas.leds_mostra;
   assign pronto      = saidas.pronto;
   assign ganhou      = saidas.ganhou;
   assign perdeu      = saidas.perdeu;
   assign db_timeout  = saidas.db_timeout;
   assign db_estado   = estado;

endmodule

// File: tb/tb_unidade_controle_exp7.sv
// Self-checking bench for unidade_controle_exp7: expected state/outputs are queued
// as each cycle's stimulus is driven and compared after the clock edge.
module tb_unidade_controle_exp7;
   import unidade_controle_exp7_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       iniciar = 1'b0, jogada = 1'b0, igual = 1'b0;
   logic       enderecoIgualRodada = 1'b0, fimR = 1'b0;
   logic       zeraE, contaE, zeraR, contaR, registraR, escreveM, leds_mostra;
   logic       pronto, ganhou, perdeu, db_timeout;
   logic [3:0] db_estado;

   typedef struct {
      string       tag;
      logic [14:0] esperado;
   } entrada_t;

   entrada_t fila[$];
   int       erros = 0;
   int       total = 0;

   unidade_controle_exp7 #(.MOSTRA_CICLOS(1000), .TIMEOUT_CICLOS(3000)) dut (
      .clock               (clock),
      .reset               (reset),
      .iniciar             (iniciar),
      .jogada              (jogada),
      .igual               (igual),
      .enderecoIgualRodada (enderecoIgualRodada),
      .fimR                (fimR),
      .zeraE               (zeraE),
      .contaE              (contaE),
      .zeraR               (zeraR),
      .contaR              (contaR),
      .registraR           (registraR),
      .escreveM            (escreveM),
      .leds_mostra         (leds_mostra),
      .pronto              (pronto),
      .ganhou              (ganhou),
      .perdeu              (perdeu),
      .db_timeout          (db_timeout),
      .db_estado           (db_estado)
   );

   always #5 clock = ~clock;

   // Order: {estado, zeraE, contaE, zeraR, contaR, registraR, escreveM, leds, pronto, ganhou, perdeu, timeout}
   function automatic logic [14:0] esperado(input logic [3:0] e);
      logic [10:0] s;
      case (e)
         4'h1:    s = 11'b101_0000_0000;
         4'h2:    s = 11'b000_0001_0000;
         4'h4:    s = 11'b000_0100_0000;
         4'h6:    s = 11'b010_0000_0000;
         4'h7:    s = 11'b010_0000_0000;
         4'h9:    s = 11'b000_0100_0000;
         4'hA:    s = 11'b000_0010_0000;
         4'hB:    s = 11'b100_1000_0000;
         4'hC:    s = 11'b000_0000_1100;
         4'hD:    s = 11'b000_0000_1010;
         4'hE:    s = 11'b000_0000_1011;
         default: s = '0;
      endcase
      return {e, s};
   endfunction

   function automatic logic [14:0] observado();
      return {db_estado, zeraE, contaE, zeraR, contaR, registraR, escreveM, leds_mostra,
              pronto, ganhou, perdeu, db_timeout};
   endfunction

   task automatic confere(input string tag, input logic [14:0] obs, input logic [14:0] exp);
      total++;
      if (obs !== exp) begin
         erros++;
         $display("FAIL %s: got estado=%h saidas=%b, expected estado=%h saidas=%b",
                  tag, obs[14:11], obs[10:0], exp[14:11], exp[10:0]);
      end
   endtask

   task automatic compara_fila();
      entrada_t e;
      if (fila.size() == 0) begin
         confere("fila_vazia", observado(), 15'h7FFF);
      end else begin
         e = fila.pop_front();
         confere(e.tag, observado(), e.esperado);
      end
   endtask

   task automatic ciclo(input logic jog, input logic ini, input logic ig, input logic eig,
                        input logic fr, input logic [3:0] est, input string tag);
      jogada = jog; iniciar = ini; igual = ig; enderecoIgualRodada = eig; fimR = fr;
      fila.push_back('{tag, esperado(est)});
      @(posedge clock);
      #1;
      jogada = 1'b0;
      compara_fila();
   endtask

   // Start request held for ini_ciclos clocks, full LED display, arrival in espera_jogada.
   task automatic partida(input int ini_ciclos);
      ciclo(0, 1, 0, 0, 0, PREPARACAO, "preparacao");
      for (int i = 0; i < 1000; i++)
         ciclo(0, (i < ini_ciclos - 1), 0, 0, 0, MOSTRA, "mostra");
      ciclo(0, 0, 0, 0, 0, ESPERA_JOGADA, "fim_mostra");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      @(posedge clock); #1;
      fila.push_back('{"reset", esperado(INICIAL)});
      compara_fila();
      reset = 1'b1;
      ciclo(0, 0, 0, 0, 0, INICIAL, "inicial_parado");
      ciclo(1, 0, 1, 1, 0, INICIAL, "jogada_ignorada_inicial");

      // Start with iniciar held 10 clocks, round 1 with write
      partida(10);
      ciclo(1, 0, 1, 1, 0, REGISTRA,         "r1_registra");
      ciclo(0, 0, 1, 1, 0, COMPARA,          "r1_compara");
      ciclo(0, 0, 1, 1, 0, AVANCA_ESCRITA,   "r1_avanca");
      ciclo(0, 0, 1, 1, 0, ESPERA_ESCRITA,   "r1_espera_escrita");
      ciclo(0, 0, 1, 1, 0, ESPERA_ESCRITA,   "r1_espera_escrita2");
      ciclo(1, 0, 1, 1, 0, REGISTRA_ESCRITA, "r1_registra_escrita");
      ciclo(0, 0, 1, 1, 0, ESCREVE,          "r1_escreve");
      ciclo(0, 0, 1, 1, 0, PROXIMA_RODADA,   "r1_proxima_rodada");
      ciclo(0, 0, 1, 1, 0, ESPERA_JOGADA,    "r1_volta_espera");

      // Round 2: first jogada correct but not last, second wrong
      ciclo(1, 0, 1, 0, 0, REGISTRA,       "r2_registra");
      ciclo(0, 0, 1, 0, 0, COMPARA,        "r2_compara");
      ciclo(0, 0, 1, 0, 0, PROXIMA_JOGADA, "r2_proxima_jogada");
      ciclo(0, 0, 1, 0, 0, ESPERA_JOGADA,  "r2_espera");
      ciclo(1, 0, 0, 1, 0, REGISTRA,       "r2_registra_erro");
      ciclo(0, 0, 0, 1, 0, COMPARA,        "r2_compara_erro");
      ciclo(0, 0, 0, 1, 0, FIM_ERROU,      "fim_errou");
      ciclo(1, 0, 0, 1, 0, FIM_ERROU,      "fim_errou_jogada_ignorada");
      ciclo(0, 0, 0, 1, 0, FIM_ERROU,      "fim_errou_mantido");

      // Restart from fim_errou, then timeout in espera_jogada
      partida(1);
      for (int i = 0; i < 2999; i++)
         ciclo(0, 0, 0, 0, 0, ESPERA_JOGADA, "espera_sem_jogada");
      ciclo(0, 0, 0, 0, 0, FIM_TIMEOUT, "timeout");
      ciclo(1, 0, 0, 0, 0, FIM_TIMEOUT, "timeout_jogada_ignorada");
      ciclo(0, 0, 0, 0, 0, FIM_TIMEOUT, "timeout_mantido");

      // Asynchronous reset mid-game in espera_jogada
      partida(1);
      for (int i = 0; i < 5; i++)
         ciclo(0, 0, 0, 0, 0, ESPERA_JOGADA, "antes_reset");
      #2 reset = 1'b0;
      #1;
      fila.push_back('{"reset_assincrono", esperado(INICIAL)});
      compara_fila();
      @(posedge clock); #1;
      fila.push_back('{"reset_mantido", esperado(INICIAL)});
      compara_fila();
      reset = 1'b1;

      // Jogada on the terminal-count clock wins over timeout; last round won
      partida(1);
      for (int i = 0; i < 2999; i++)
         ciclo(0, 0, 0, 0, 0, ESPERA_JOGADA, "espera_ate_limite");
      ciclo(1, 0, 1, 1, 1, REGISTRA,    "jogada_no_limite");
      ciclo(0, 0, 1, 1, 1, COMPARA,     "ultima_compara");
      ciclo(0, 0, 1, 1, 1, FIM_ACERTOU, "fim_acertou");
      for (int i = 0; i < 3; i++)
         ciclo(0, 0, 1, 1, 1, FIM_ACERTOU, "fim_acertou_mantido");
      ciclo(0, 1, 0, 0, 0, PREPARACAO, "reinicio_flags_zero");
      ciclo(0, 0, 0, 0, 0, MOSTRA,     "reinicio_mostra");

      $display("Result: errors=%0d of %0d checks", erros, total);
      $finish;
   end

endmodule
